// File: rtl/aes_shift_mix_stage.sv
// -----------------------------------------------------------------------------
// aes_shift_mix_stage
//
// Forward AES round stage. It applies ShiftRows and then MixColumns to a
// 128-bit state. MixColumns is bypassed on the final round. The stage sits
// between SubBytes and AddRoundKey. The transform is combinational on the
// input side, and the result is stored in a two-entry buffer: an output
// register (OR) plus a skid register (SK). Backpressure therefore never drops
// or duplicates a state.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers in_state / in_last / in_tag
//   in_ready   stage can accept (registered: skid slot empty)
//   in_state   SubBytes output; byte k = bits [8k:8k+7] = row k%4, column k/4
//   in_last    final round, so MixColumns is skipped
//   in_tag     opaque round tag, passed through unchanged
//   out_valid  out_state / out_last / out_tag hold a valid entry
//   out_ready  downstream accepts
//   out_state  ShiftRows (+ MixColumns) result, same byte ordering as input
//   out_last   in_last of this entry
//   out_tag    in_tag of this entry
// -----------------------------------------------------------------------------
module aes_shift_mix_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_state,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_state,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag
);

    // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // MixColumns on one column; a0 is the top (row 0) byte
    function automatic logic [0:31] mix_column(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        // 3x is computed as 2x ^ x
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Forward ShiftRows: out bytes 0..15 <- in bytes 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        return {s[0:7],   s[40:47],  s[80:87],   s[120:127],
                s[32:39], s[72:79],  s[112:119], s[24:31],
                s[64:71], s[104:111], s[16:23],  s[56:63],
                s[96:103], s[8:15],  s[48:55],   s[88:95]};
    endfunction

    logic [0:127]     shifted_s;
    logic [0:127]     mixed_s;
    logic [0:127]     xform_s;
    logic             accept_s;
    logic             drain_s;

    logic             or_valid_q, or_valid_d;
    logic [0:127]     or_state_q, or_state_d;
    logic             or_last_q,  or_last_d;
    logic [TAG_W-1:0] or_tag_q,   or_tag_d;
    logic             sk_valid_q, sk_valid_d;
    logic [0:127]     sk_state_q, sk_state_d;
    logic             sk_last_q,  sk_last_d;
    logic [TAG_W-1:0] sk_tag_q,   sk_tag_d;

    // Input-side transform; only the transformed state is ever stored
    always_comb begin
        shifted_s = shift_rows(in_state);
        mixed_s   = {mix_column(shifted_s[0:31]),  mix_column(shifted_s[32:63]),
                     mix_column(shifted_s[64:95]), mix_column(shifted_s[96:127])};
        if (in_last) begin
            xform_s = shifted_s;
        end else begin
            xform_s = mixed_s;
        end
    end

    assign in_ready  = ~sk_valid_q;
    assign accept_s  = in_valid & ~sk_valid_q;
    assign drain_s   = or_valid_q & out_ready;

    assign out_valid = or_valid_q;
    assign out_state = or_state_q;
    assign out_last  = or_last_q;
    assign out_tag   = or_tag_q;

    // Next-state for the two-entry OR/SK buffer
    always_comb begin
        or_valid_d = or_valid_q;
        or_state_d = or_state_q;
        or_last_d  = or_last_q;
        or_tag_d   = or_tag_q;
        sk_valid_d = sk_valid_q;
        sk_state_d = sk_state_q;
        sk_last_d  = sk_last_q;
        sk_tag_d   = sk_tag_q;
        if (drain_s && sk_valid_q) begin
            // SK is older than anything upstream; no accept can coincide (in_ready=0)
            or_state_d = sk_state_q;
            or_last_d  = sk_last_q;
            or_tag_d   = sk_tag_q;
            sk_valid_d = 1'b0;
        end else if (accept_s && (!or_valid_q || drain_s)) begin
            or_valid_d = 1'b1;
            or_state_d = xform_s;
            or_last_d  = in_last;
            or_tag_d   = in_tag;
        end else if (accept_s) begin
            // OR is full and stalled, so the new entry parks in SK
            sk_valid_d = 1'b1;
            sk_state_d = xform_s;
            sk_last_d  = in_last;
            sk_tag_d   = in_tag;
        end else if (drain_s) begin
            or_valid_d = 1'b0;
        end else begin
            or_valid_d = or_valid_q;
        end
    end

    // Buffer registers; data is cleared too so outputs read 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_state_q <= 128'h0;
            or_last_q  <= 1'b0;
            or_tag_q   <= {TAG_W{1'b0}};
            sk_valid_q <= 1'b0;
            sk_state_q <= 128'h0;
            sk_last_q  <= 1'b0;
            sk_tag_q   <= {TAG_W{1'b0}};
        end else begin
            or_valid_q <= or_valid_d;
            or_state_q <= or_state_d;
            or_last_q  <= or_last_d;
            or_tag_q   <= or_tag_d;
            sk_valid_q <= sk_valid_d;
            sk_state_q <= sk_state_d;
            sk_last_q  <= sk_last_d;
            sk_tag_q   <= sk_tag_d;
        end
    end

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// -----------------------------------------------------------------------------
// tb_aes_shift_mix_stage
//
// Directed testbench for aes_shift_mix_stage. Inputs are driven and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_aes_shift_mix_stage;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         in_last;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic         out_last;
    logic [3:0]   out_tag;

    int tests_run;
    int tests_failed;

    localparam logic [0:127] FIPS_IN    = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [0:127] FIPS_MIX   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [0:127] FIPS_SHIFT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] COL_IN     = 128'hdb000000001300000000530000000045;
    localparam logic [0:127] COL_OUT    = 128'h8e4da1bc000000000000000000000000;

    aes_shift_mix_stage #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1B;
        end
        return p;
    endfunction

    // Reference: byte-array ShiftRows, then circulant-matrix MixColumns
    function automatic logic [0:127] ref_model(input logic [0:127] s, input logic last);
        logic [7:0]   a[16];
        logic [7:0]   sh[16];
        logic [7:0]   o[16];
        logic [7:0]   m[4];
        logic [0:127] r;
        m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        for (int k = 0; k < 16; k++) a[k] = s[8*k +: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                sh[row + 4*c] = a[row + 4*((c + row) % 4)];
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                if (last) begin
                    o[4*c + i] = sh[4*c + i];
                end else begin
                    o[4*c + i] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        o[4*c + i] = o[4*c + i] ^ gmul(m[(j - i + 4) % 4], sh[4*c + j]);
                end
            end
        for (int k = 0; k < 16; k++) r[8*k +: 8] = o[k];
        return r;
    endfunction

    // Offer one entry for exactly one edge (stimulus only)
    task automatic send_one(input logic [0:127] s, input logic l, input logic [3:0] t);
        in_valid = 1'b1;
        in_state = s;
        in_last  = l;
        in_tag   = t;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        in_last   = 1'b0;
        in_tag    = 4'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++;
        if (out_state !== 128'h0 || out_last !== 1'b0 || out_tag !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h/%b/%h exp=0/0/0", out_state, out_last, out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_mix;
        out_ready = 1'b1;
        send_one(FIPS_IN, 1'b0, 4'd3);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL fips_mix_valid got=%b exp=1", out_valid); end
        tests_run++;
        if (out_state !== FIPS_MIX) begin tests_failed++; $display("FAIL fips_mix_state got=%h exp=%h", out_state, FIPS_MIX); end
        tests_run++;
        if (out_tag !== 4'd3 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL fips_mix_tag got=%h/%b exp=3/0", out_tag, out_last);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fips_mix_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_final_round;
        out_ready = 1'b1;
        send_one(FIPS_IN, 1'b1, 4'd9);
        tests_run++;
        if (out_state !== FIPS_SHIFT) begin tests_failed++; $display("FAIL final_state got=%h exp=%h", out_state, FIPS_SHIFT); end
        tests_run++;
        if (out_last !== 1'b1 || out_tag !== 4'd9) begin
            tests_failed++;
            $display("FAIL final_last_tag got=%b/%h exp=1/9", out_last, out_tag);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_column;
        out_ready = 1'b1;
        send_one(COL_IN, 1'b0, 4'd7);
        tests_run++;
        if (out_state !== COL_OUT) begin tests_failed++; $display("FAIL single_column got=%h exp=%h", out_state, COL_OUT); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [3:0] got[8];
        int         n;
        logic       drain_now;
        logic       acc_now;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        in_state  = FIPS_IN;
        in_tag    = 4'd1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after_1 got=%b exp=1", in_ready); end
        in_state = COL_IN;
        in_tag   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_after_2 got=%b exp=0", in_ready); end
        in_state = FIPS_IN;
        in_tag   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
            tests_failed++;
            $display("FAIL bp_stalled got ready=%b valid=%b tag=%h exp 0/1/1", in_ready, out_valid, out_tag);
        end
        tests_run++;
        if (out_state !== FIPS_MIX) begin tests_failed++; $display("FAIL bp_head_state got=%h exp=%h", out_state, FIPS_MIX); end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            drain_now = out_valid;
            acc_now   = in_valid && in_ready;
            if (drain_now && n < 8) begin
                got[n] = out_tag;
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc_now) in_valid = 1'b0;
        end
        tests_run++;
        if (n !== 3) begin tests_failed++; $display("FAIL bp_count got=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i < n && got[i] !== 4'(i + 1)) begin
                tests_failed++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], 4'(i + 1));
            end
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_recovered got=%b exp=1", in_ready); end
    endtask

    task automatic test_streaming;
        logic [0:127] s;
        logic [0:127] e;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = 1'b1;
            in_state = s;
            in_last  = (i % 4 == 3);
            in_tag   = 4'(i);
            e        = ref_model(s, (i % 4 == 3));
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_state !== e || out_tag !== 4'(i)) begin
                tests_failed++;
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_state, out_tag, e, 4'(i));
            end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = COL_IN;
        in_last   = 1'b0;
        in_tag    = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_tag = 4'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_full got ready=%b valid=%b exp 0/1", in_ready, out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_immediate got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_first_cycle got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        send_one(FIPS_IN, 1'b0, 4'd4);
        tests_run++;
        if (out_valid !== 1'b1 || out_state !== FIPS_MIX || out_tag !== 4'd4) begin
            tests_failed++;
            $display("FAIL arst_after got=%b/%h/%h exp=1/%h/4", out_valid, out_state, out_tag, FIPS_MIX);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fips_mix();
        test_final_round();
        test_single_column();
        test_backpressure();
        test_streaming();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
